// File: rtl/booth_mul_pipe.sv
// Three-stage pipelined radix-4 Booth / Wallace multiplier, unsigned or signed per transaction,
// with valid/ready flow control and a sideband tag carried alongside each product.
module booth_mul_pipe #(
   parameter int unsigned N     = 24,
   parameter int unsigned TAG_W = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic               i_signed,
   input  logic [N-1:0]       i_a,
   input  logic [N-1:0]       i_b,
   input  logic [TAG_W-1:0]   i_tag,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [2*N-1:0]     o_product,
   output logic [TAG_W-1:0]   o_tag
);

   localparam int unsigned P  = 2 * N;       // product width
   localparam int unsigned E  = N + 2;       // extended operand width
   localparam int unsigned W  = N + 3;       // partial-product width (covers 2*a)
   localparam int unsigned K  = N / 2 + 1;   // Booth digits
   localparam int unsigned R  = K + 1;       // rows into the tree (digits + negate row)
   localparam int unsigned T  = 3 * R - 4;   // tree scratch rows
   localparam int unsigned LV = $clog2(P);   // prefix-adder levels

   // FIFO-ordered 3:2 compression: each step eats three rows and appends two.
   function automatic logic [2*P-1:0] reduce(input logic [P-1:0] rows [R]);
      logic [P-1:0] t [T];
      for (int r = 0; r < int'(T); r++) t[r] = '0;
      for (int r = 0; r < int'(R); r++) t[r] = rows[r];
      for (int s = 0; s < int'(R) - 2; s++) begin
         t[int'(R) + 2*s]     = t[3*s] ^ t[3*s+1] ^ t[3*s+2];
         t[int'(R) + 2*s + 1] = ((t[3*s] & t[3*s+1]) | (t[3*s] & t[3*s+2]) |
                                 (t[3*s+1] & t[3*s+2])) << 1;
      end
      return {t[T-2], t[T-1]};
   endfunction

   // Kogge-Stone carry-lookahead adder, carry-in 0, result mod 2^P.
   function automatic logic [P-1:0] cla(input logic [P-1:0] x, input logic [P-1:0] y);
      logic [P-1:0] g;
      logic [P-1:0] h;
      g = x & y;
      h = x ^ y;
      for (int l = 0; l < int'(LV); l++) begin
         g = g | (h & (g << (1 << l)));
         h = h & (h << (1 << l));
      end
      return (x ^ y) ^ {g[P-2:0], 1'b0};
   endfunction

   logic [E-1:0]     a_ext;
   logic [E-1:0]     b_ext;
   logic [E:0]       b_pad;
   logic [W-1:0]     a_w;
   logic [W-1:0]     mag;
   logic [W-1:0]     pat;
   logic             neg;
   logic [P-1:0]     pp [R];
   logic [P-1:0]     neg_row;
   logic [P-1:0]     m_vec;
   logic [P-1:0]     red_sum;
   logic [P-1:0]     red_carry;

   logic             v1;
   logic             v2;
   logic             ld1;
   logic             ld2;
   logic             ld3;
   logic             in_xfer;
   logic [P-1:0]     s1_sum;
   logic [P-1:0]     s1_carry;
   logic [P-1:0]     s1_m;
   logic [TAG_W-1:0] s1_tag;
   logic [P-1:0]     s2_r0;
   logic [P-1:0]     s2_r1;
   logic [TAG_W-1:0] s2_tag;

   // Booth recoding; each row has its MSB flipped so sign extension folds into the constant m_vec.
   always_comb begin
      a_ext   = i_signed ? {{2{i_a[N-1]}}, i_a} : {2'b00, i_a};
      b_ext   = i_signed ? {{2{i_b[N-1]}}, i_b} : {2'b00, i_b};
      b_pad   = {b_ext, 1'b0};
      a_w     = {a_ext[E-1], a_ext};
      mag     = '0;
      pat     = '0;
      neg     = 1'b0;
      neg_row = '0;
      m_vec   = '0;
      for (int r = 0; r < int'(R); r++) pp[r] = '0;
      for (int j = 0; j < int'(K); j++) begin
         mag = '0;
         neg = 1'b0;
         case (b_pad[2*j +: 3])
            3'b001, 3'b010: mag = a_w;
            3'b011:         mag = a_w << 1;
            3'b100:         begin mag = a_w << 1; neg = 1'b1; end
            3'b101, 3'b110: begin mag = a_w;      neg = 1'b1; end
            default:        mag = '0;
         endcase
         pat          = neg ? ~mag : mag;
         pat[W-1]     = ~pat[W-1];
         pp[j]        = P'(pat) << (2 * j);
         neg_row[2*j] = neg;
         m_vec        = m_vec - (P'(1) << (int'(W) - 1 + 2 * j));
      end
      pp[K] = neg_row;
   end

   always_comb begin
      {red_sum, red_carry} = reduce(pp);
   end

   // Stage k advances when empty or when its successor advances; the output stage frees on i_ready.
   always_comb begin
      ld3     = !o_valid || i_ready;
      ld2     = !v2 || ld3;
      ld1     = !v1 || ld2;
      o_ready = !i_rst && ld1;
      in_xfer = i_valid && o_ready;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         o_valid   <= 1'b0;
         s1_sum    <= '0;
         s1_carry  <= '0;
         s1_m      <= '0;
         s1_tag    <= '0;
         s2_r0     <= '0;
         s2_r1     <= '0;
         s2_tag    <= '0;
         o_product <= '0;
         o_tag     <= '0;
      end else begin
         if (ld1) v1 <= in_xfer;
         if (in_xfer) begin
            s1_sum   <= red_sum;
            s1_carry <= red_carry;
            s1_m     <= m_vec;
            s1_tag   <= i_tag;
         end
         if (ld2) v2 <= v1;
         if (ld2 && v1) begin
            s2_r0  <= s1_sum ^ s1_carry ^ s1_m;
            s2_r1  <= ((s1_sum & s1_carry) | (s1_sum & s1_m) | (s1_carry & s1_m)) << 1;
            s2_tag <= s1_tag;
         end
         if (ld3) o_valid <= v2;
         if (ld3 && v2) begin
            o_product <= cla(s2_r0, s2_r1);
            o_tag     <= s2_tag;
         end
      end
   end

endmodule

// File: tb/tb_booth_mul_pipe.sv
// Scoreboard bench for booth_mul_pipe: directed vectors plus a model-checked random batch.
module tb_booth_mul_pipe;

   localparam int unsigned N  = 24;
   localparam int unsigned TW = 4;
   localparam int unsigned P  = 2 * N;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_valid;
   logic          o_ready;
   logic          i_signed;
   logic [N-1:0]  i_a;
   logic [N-1:0]  i_b;
   logic [TW-1:0] i_tag;
   logic          o_valid;
   logic          i_ready;
   logic [P-1:0]  o_product;
   logic [TW-1:0] o_tag;

   always #5 clk = ~clk;

   booth_mul_pipe #(.N(N), .TAG_W(TW)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_signed(i_signed), .i_a(i_a), .i_b(i_b), .i_tag(i_tag),
      .o_valid(o_valid), .i_ready(i_ready), .o_product(o_product), .o_tag(o_tag)
   );

   typedef struct {
      logic [P-1:0]  prod;
      logic [TW-1:0] tag;
      logic          lat;
      time           acc;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          mon_e;
   int            n_cmp = 0;
   int            n_bad = 0;
   int            n_acc = 0;
   int            streak = 0;
   int            streak_max = 0;
   logic          held = 1'b0;
   logic [P-1:0]  held_prod;
   logic [TW-1:0] held_tag;
   logic          rnd_rdy = 1'b0;

   logic          vs [12];
   logic [N-1:0]  va [12];
   logic [N-1:0]  vb [12];
   logic [P-1:0]  vp [12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [P-1:0] model(input logic sg, input logic [N-1:0] a,
                                          input logic [N-1:0] b);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic signed [63:0] pr;
      sa = sg ? {{(64-N){a[N-1]}}, a} : {{(64-N){1'b0}}, a};
      sb = sg ? {{(64-N){b[N-1]}}, b} : {{(64-N){1'b0}}, b};
      pr = sa * sb;
      return pr[P-1:0];
   endfunction

   // Drive on the falling edge, decide acceptance just before the rising edge.
   task automatic send(input logic sg, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [TW-1:0] tag, input logic [P-1:0] prod,
                       input logic push, input logic lat);
      exp_t e;
      bit   done;
      done = 1'b0;
      @(negedge clk);
      i_valid  = 1'b1;
      i_signed = sg;
      i_a      = a;
      i_b      = b;
      i_tag    = tag;
      for (int t = 0; t < 60 && !done; t++) begin
         #4;
         if (o_ready) begin
            if (push) begin
               e.prod = prod; e.tag = tag; e.lat = lat; e.acc = $time + 1;
               exp_q.push_back(e);
            end
            @(posedge clk);
            n_acc++;
            done = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL accept_timeout: o_ready stayed 0, expected an accept within 60 cycles");
      end
   endtask

   task automatic idle();
      @(negedge clk);
      i_valid = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge clk);
      check("drain_outstanding", 64'(exp_q.size()), 64'd0);
   endtask

   always @(negedge clk) begin
      if (rnd_rdy) i_ready = ($urandom_range(0, 3) != 0);
   end

   // Monitor: samples just before each rising edge and pops on every output transfer.
   always @(negedge clk) begin
      #4;
      if (rst) begin
         held   = 1'b0;
         streak = 0;
      end else begin
         if (o_valid) begin
            streak++;
            if (streak > streak_max) streak_max = streak;
         end else begin
            streak = 0;
         end
         if (o_valid && held) begin
            check("stall_hold_product", 64'(o_product), 64'(held_prod));
            check("stall_hold_tag", 64'(o_tag), 64'(held_tag));
         end
         if (o_valid && !i_ready) begin
            held = 1'b1; held_prod = o_product; held_tag = o_tag;
         end else begin
            held = 1'b0;
         end
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_output: got product 0x%0h tag %0d, expected no output",
                        o_product, o_tag);
            end else begin
               mon_e = exp_q.pop_front();
               check("product", 64'(o_product), 64'(mon_e.prod));
               check("tag", 64'(o_tag), 64'(mon_e.tag));
               if (mon_e.lat) check("latency_time", 64'($time - mon_e.acc), 64'd29);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion well before the limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vs[0]  = 1'b0; va[0]  = 24'hFFFFFF; vb[0]  = 24'hFFFFFF; vp[0]  = 48'hFFFFFE000001;
      vs[1]  = 1'b1; va[1]  = 24'hFFFFFF; vb[1]  = 24'hFFFFFF; vp[1]  = 48'h000000000001;
      vs[2]  = 1'b1; va[2]  = 24'h800000; vb[2]  = 24'h800000; vp[2]  = 48'h400000000000;
      vs[3]  = 1'b1; va[3]  = 24'hFFFFFF; vb[3]  = 24'h000001; vp[3]  = 48'hFFFFFFFFFFFF;
      vs[4]  = 1'b0; va[4]  = 24'h000003; vb[4]  = 24'h000005; vp[4]  = 48'h00000000000F;
      vs[5]  = 1'b1; va[5]  = 24'h000002; vb[5]  = 24'hFFFFFD; vp[5]  = 48'hFFFFFFFFFFFA;
      vs[6]  = 1'b1; va[6]  = 24'h7FFFFF; vb[6]  = 24'h7FFFFF; vp[6]  = 48'h3FFFFF000001;
      vs[7]  = 1'b1; va[7]  = 24'h800000; vb[7]  = 24'h7FFFFF; vp[7]  = 48'hC00000800000;
      vs[8]  = 1'b0; va[8]  = 24'h123456; vb[8]  = 24'h000010; vp[8]  = 48'h000001234560;
      vs[9]  = 1'b0; va[9]  = 24'h000000; vb[9]  = 24'hFFFFFF; vp[9]  = 48'h000000000000;
      vs[10] = 1'b0; va[10] = 24'hFFFFFF; vb[10] = 24'h000001; vp[10] = 48'h000000FFFFFF;
      vs[11] = 1'b0; va[11] = 24'h800000; vb[11] = 24'h000002; vp[11] = 48'h000001000000;

      rst = 1'b1; i_valid = 1'b0; i_signed = 1'b0; i_a = '0; i_b = '0; i_tag = '0; i_ready = 1'b1;
      repeat (3) @(negedge clk);
      #4;
      check("reset_o_valid", 64'(o_valid), 64'd0);
      check("reset_o_ready", 64'(o_ready), 64'd0);
      check("reset_o_product", 64'(o_product), 64'd0);
      check("reset_o_tag", 64'(o_tag), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #4;
      check("ready_after_reset", 64'(o_ready), 64'd1);

      // Isolated directed vectors, each with a latency check.
      for (int k = 0; k < 12; k++) begin
         send(vs[k], va[k], vb[k], TW'(k), vp[k], 1'b1, 1'b1);
         idle();
         drain();
      end

      // Back-to-back burst of 8 with tags 0..7.
      streak_max = 0;
      for (int k = 0; k < 8; k++) send(vs[k], va[k], vb[k], TW'(k), vp[k], 1'b1, 1'b0);
      idle();
      drain();
      check("b2b_valid_streak", 64'(streak_max), 64'd8);

      // Output stalled for 6 cycles under continuous input.
      begin
         int base;
         base = n_acc;
         fork
            begin
               for (int k = 0; k < 6; k++)
                  send(vs[k+4], va[k+4], vb[k+4], TW'(8 + k), vp[k+4], 1'b1, 1'b0);
               idle();
            end
            begin
               i_ready = 1'b0;
               repeat (6) @(negedge clk);
               #4;
               check("stall_accept_count", 64'(n_acc - base), 64'd3);
               check("stall_o_ready", 64'(o_ready), 64'd0);
               @(negedge clk);
               i_ready = 1'b1;
            end
         join
      end
      drain();

      // Reset with two operations in flight: they must vanish.
      send(vs[0], va[0], vb[0], 4'd1, vp[0], 1'b0, 1'b0);
      send(vs[1], va[1], vb[1], 4'd2, vp[1], 1'b0, 1'b0);
      @(negedge clk);
      i_valid = 1'b0;
      rst     = 1'b1;
      @(negedge clk);
      #4;
      check("midrst_o_valid", 64'(o_valid), 64'd0);
      check("midrst_o_ready", 64'(o_ready), 64'd0);
      check("midrst_o_product", 64'(o_product), 64'd0);
      check("midrst_o_tag", 64'(o_tag), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #4;
      check("midrst_ready_after", 64'(o_ready), 64'd1);
      repeat (8) @(negedge clk);
      check("midrst_no_stale", 64'(o_valid), 64'd0);

      // Random operands and backpressure against the reference model.
      rnd_rdy = 1'b1;
      for (int k = 0; k < 400; k++) begin
         logic          sg;
         logic [N-1:0]  a;
         logic [N-1:0]  b;
         sg = 1'($urandom_range(0, 1));
         a  = N'($urandom);
         b  = N'($urandom);
         if (k % 16 == 0) a = {1'b1, {(N-1){1'b0}}};
         if (k % 16 == 1) b = '1;
         send(sg, a, b, TW'($urandom), model(sg, a, b), 1'b1, 1'b0);
         if ($urandom_range(0, 4) == 0) idle();
      end
      idle();
      @(negedge clk);
      rnd_rdy = 1'b0;
      i_ready = 1'b1;
      drain();
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
